// File: rtl/mult5_pkg.sv
// mult5_pkg: shared types, default parameters and the remainder step for the
// multiple-of-DIV serial path (transmitter now, serial receiver later).
package mult5_pkg;

  // Frame sequencing states of the transmitter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAG   = 2'd2
  } state_e;

  localparam int DW_DEF  = 6;
  localparam int DIV_DEF = 5;
  localparam int CW_DEF  = 8;

  // Next remainder after appending bit b below the running value:
  // (2*rem + b) mod div. Since rem < div, the sum is below 2*div, so
  // one conditional subtract is enough.
  function automatic int rem_step(input int rem, input logic b, input int div);
    int sum;
    sum = 2 * rem + int'(b);
    if (sum >= div) begin
      sum = sum - div;
    end
    return sum;
  endfunction

endpackage

// File: rtl/mult5_serial_tx_mod_rem_fsm.sv
// mod_rem_fsm: running remainder of an MSB-first bit stream modulo DIV.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears the remainder
//   clear    restart the remainder from zero
//   step     fold bit_in into the remainder this edge
//   bit_in   next lower bit of the stream
//   is_zero  remainder register equals zero
//
// clear together with step loads the first bit of a new stream, so a frame
// can start in the same cycle the previous one ends.
module mod_rem_fsm
  import mult5_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic bit_in,
  output logic is_zero
);

  // One bit wider than the remainder range so 2*rem+b fits before reduction.
  localparam int RW = $clog2(DIV) + 1;

  logic [RW-1:0] rem_q;
  logic [RW-1:0] rem_d;
  logic [RW-1:0] base;

  always_comb begin
    rem_d = rem_q;
    base  = clear ? '0 : rem_q;
    if (step) begin
      rem_d = RW'(rem_step(int'(base), bit_in, DIV));
    end else if (clear) begin
      rem_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign is_zero = (rem_q == '0);

endmodule

// File: rtl/mult5_serial_tx.sv
// mult5_serial_tx: accepts a DW-bit word on a valid/ready handshake and sends
// it MSB-first on sout, followed by one tag bit that is 1 when the word is a
// multiple of DIV. mult_cnt counts tagged-multiple frames (wrapping).
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          global enable; low pauses the block without losing bits
//   din         parallel input word, sampled only at the handshake edge
//   din_valid   din is valid
//   din_ready   word can be accepted this cycle (combinational)
//   sout        serial data / tag bit (registered, holds while idle/paused)
//   sout_valid  sout carries a frame bit this cycle
//   sof         first (MSB) data bit of a frame
//   eof         tag bit of a frame
//   mult_cnt    number of frames sent with tag 1
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no frame on sout; waiting for a word
// ST_SHIFT | a data bit is on sout; bit_cnt data bits still to launch
// ST_TAG   | tag bit is on sout; a new word may be accepted (no bubble)
module mult5_serial_tx
  import mult5_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int DIV = DIV_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          sout,
  output logic          sout_valid,
  output logic          sof,
  output logic          eof,
  output logic [CW-1:0] mult_cnt
);

  localparam int NW = $clog2(DW);

  state_e        state_q, state_d;
  logic [NW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic [CW-1:0] mult_cnt_q, mult_cnt_d;

  logic          rem_clear;
  logic          rem_step_en;
  logic          rem_bit;
  logic          rem_zero;

  mod_rem_fsm #(
    .DIV(DIV)
  ) u_rem (
    .clk    (clk),
    .rst    (rst),
    .clear  (rem_clear),
    .step   (rem_step_en),
    .bit_in (rem_bit),
    .is_zero(rem_zero)
  );

  assign din_ready = en && ((state_q == ST_IDLE) || (state_q == ST_TAG));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    mult_cnt_d   = mult_cnt_q;
    rem_clear    = 1'b0;
    rem_step_en  = 1'b0;
    rem_bit      = 1'b0;

    // With en low nothing advances; the frame flags drop for the paused
    // cycle and sout keeps its value.
    if (en) begin
      unique case (state_q)
        ST_IDLE, ST_TAG: begin
          if (din_valid) begin
            // MSB goes out now; the shift register keeps the remaining
            // bits left-aligned so the next bit is always at DW-1.
            sout_d       = din[DW-1];
            sout_valid_d = 1'b1;
            sof_d        = 1'b1;
            shreg_d      = din << 1;
            bit_cnt_d    = NW'(DW - 1);
            rem_clear    = 1'b1;
            rem_step_en  = 1'b1;
            rem_bit      = din[DW-1];
            state_d      = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_SHIFT: begin
          sout_valid_d = 1'b1;
          if (bit_cnt_q != '0) begin
            sout_d      = shreg_q[DW-1];
            shreg_d     = shreg_q << 1;
            bit_cnt_d   = bit_cnt_q - NW'(1);
            rem_step_en = 1'b1;
            rem_bit     = shreg_q[DW-1];
          end else begin
            // All data bits are folded into the remainder: emit the tag.
            sout_d  = rem_zero;
            eof_d   = 1'b1;
            state_d = ST_TAG;
            if (rem_zero) begin
              mult_cnt_d = mult_cnt_q + CW'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      mult_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      mult_cnt_q   <= mult_cnt_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign mult_cnt   = mult_cnt_q;

endmodule

// File: tb/tb_mult5_serial_tx.sv
module tb_mult5_serial_tx;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sof;
  logic       eof;
  logic [7:0] mult_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] c_sout, c_val, c_sof, c_eof;

  mult5_serial_tx #(.DW(6), .DIV(5), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sof       (sof),
    .eof       (eof),
    .mult_cnt  (mult_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap_clr();
    c_sout = '0;
    c_val  = '0;
    c_sof  = '0;
    c_eof  = '0;
  endtask

  // Sample the outputs for n cycles (oldest sample ends up most significant).
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      c_sout = {c_sout[62:0], sout};
      c_val  = {c_val[62:0], sout_valid};
      c_sof  = {c_sof[62:0], sof};
      c_eof  = {c_eof[62:0], eof};
      tick();
    end
  endtask

  // Present w until the handshake edge; afterwards the MSB is on sout.
  task automatic send_word(input logic [5:0] w, input bit keep_valid);
    bit hs;
    hs = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (din_ready) hs = 1'b1;
      tick();
    end
    if (!keep_valid) din_valid = 1'b0;
    chk("handshake", 64'(hs), 64'd1);
  endtask

  task automatic frame_chk(input string tag, input logic [5:0] w, input logic t);
    send_word(w, 1'b0);
    din = ~w;
    cap_clr();
    cap(8);
    chk({tag, "_sout"}, c_sout[7:0], {w, t, t});
    chk({tag, "_valid"}, c_val[7:0], 8'hFE);
    chk({tag, "_sof"}, c_sof[7:0], 8'h80);
    chk({tag, "_eof"}, c_eof[7:0], 8'h02);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tags;
    int vcnt;
    rst = 1'b1;
    en = 1'b1;
    din = '0;
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_sout", 64'(sout), 64'd0);
    chk("rst_valid", 64'(sout_valid), 64'd0);
    chk("rst_sof", 64'(sof), 64'd0);
    chk("rst_eof", 64'(eof), 64'd0);
    chk("rst_cnt", 64'(mult_cnt), 64'd0);
    chk("rst_ready", 64'(din_ready), 64'd1);
    en = 1'b0;
    #1;
    chk("ready_en0", 64'(din_ready), 64'd0);
    en = 1'b1;
    #1;

    // Single frames
    frame_chk("f45", 6'd45, 1'b1);
    chk("cnt_45", 64'(mult_cnt), 64'd1);
    frame_chk("f63", 6'd63, 1'b0);
    chk("cnt_63", 64'(mult_cnt), 64'd1);
    frame_chk("f0", 6'd0, 1'b1);
    chk("cnt_0", 64'(mult_cnt), 64'd2);

    // Back-to-back 5 then 7 with din_valid held across the boundary
    send_word(6'd5, 1'b1);
    din = 6'd7;
    cap_clr();
    cap(8);
    din_valid = 1'b0;
    cap(6);
    chk("b2b_valid", c_val[13:0], 14'h3FFF);
    chk("b2b_sout", c_sout[13:0], {6'd5, 1'b1, 6'd7, 1'b0});
    chk("b2b_sof", c_sof[13:0], 14'b10000001000000);
    chk("b2b_eof", c_eof[13:0], 14'b00000010000001);
    tick();
    chk("cnt_b2b", 64'(mult_cnt), 64'd3);

    // Pause: en low for 3 cycles after the third bit of 50 (110010)
    send_word(6'd50, 1'b0);
    cap_clr();
    cap(2);
    chk("ready_shift", 64'(din_ready), 64'd0);
    en = 1'b0;
    din_valid = 1'b1;
    cap(3);
    chk("ready_paused", 64'(din_ready), 64'd0);
    en = 1'b1;
    din_valid = 1'b0;
    cap(5);
    chk("pause_valid", c_val[9:0], 10'b1110001111);
    chk("pause_sout", c_sout[9:0], 10'b1100000101);
    chk("pause_sof", c_sof[9:0], 10'b1000000000);
    chk("pause_eof", c_eof[9:0], 10'b0000000001);
    chk("pause_nvalid", 64'($countones(c_val[9:0])), 64'd7);
    tick();
    chk("cnt_50", 64'(mult_cnt), 64'd4);

    // Reset during the 4th bit of 25 (011001)
    send_word(6'd25, 1'b0);
    cap_clr();
    cap(3);
    chk("r25_bit4", {sout_valid, sout}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 64'(sout_valid), 64'd0);
    chk("abort_eof", 64'(eof), 64'd0);
    chk("abort_cnt", 64'(mult_cnt), 64'd0);
    chk("abort_ready", 64'(din_ready), 64'd1);
    tick();
    chk("abort_no_tag", {sout_valid, eof}, 2'b00);
    frame_chk("f10", 6'd10, 1'b1);
    chk("cnt_10", 64'(mult_cnt), 64'd1);

    // Reset wins over a simultaneous handshake
    din = 6'd5;
    din_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    chk("rst_hs_valid", 64'(sout_valid), 64'd0);
    tick();
    chk("rst_hs_valid2", 64'(sout_valid), 64'd0);
    chk("rst_hs_cnt", 64'(mult_cnt), 64'd0);

    // Sweep 0..63 with en high
    tags = 0;
    for (int w = 0; w < 64; w++) begin
      send_word(6'(w), 1'b0);
      cap_clr();
      cap(7);
      chk("sweep_frame", {c_val[6:0], c_sout[6:0]}, {7'h7F, 6'(w), ((w % 5) == 0)});
      tags += int'(c_sout[0]);
    end
    tick();
    chk("sweep_tags", 64'(tags), 64'd13);
    chk("sweep_cnt", 64'(mult_cnt), 64'd13);

    // Sweep 0..63 with en low: nothing may happen
    en = 1'b0;
    vcnt = 0;
    for (int w = 0; w < 64; w++) begin
      din = 6'(w);
      din_valid = 1'b1;
      cap_clr();
      cap(2);
      vcnt += $countones(c_val[1:0]) + int'(din_ready);
    end
    din_valid = 1'b0;
    chk("off_activity", 64'(vcnt), 64'd0);
    chk("off_cnt", 64'(mult_cnt), 64'd13);
    en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult5_serial_tx.md
Name: mult5_serial_tx

Overview:
- Serial transmitter for 6-bit words. It accepts a parallel word on a valid/ready handshake and shifts it out MSB-first on a one-bit line.
- While the bits go out, a remainder-mod-DIV FSM tracks the running value. A tag bit follows the data: 1 when the word is a multiple of DIV.
- It is the sending end of the multiple-of-5 detection path. A serial checker can strip the tag and compare it against its own result.

Parameters:
- DW, 6, data word width in bits (>=2)
- DIV, 5, divisor checked by the remainder FSM (>=2)
- CW, 8, width of the multiple-found counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; low pauses the block
- din  in  DW  parallel input word
- din_valid  in  1  din is valid
- din_ready  out  1  block can accept a word this cycle
- sout  out  1  serial data/tag bit
- sout_valid  out  1  sout carries a frame bit this cycle
- sof  out  1  first data bit of a frame (din MSB)
- eof  out  1  tag bit of a frame
- mult_cnt  out  CW  number of tagged-multiple frames sent, wraps

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high; rst high at a rising edge clears all state.
  - Outputs after reset: sout=0, sout_valid=0, sof=0, eof=0, mult_cnt=0, FSM=IDLE, remainder=0, bit counter=0.
  - rst asserted mid-frame aborts the frame. No partial tag is emitted and the counter is cleared.
- All outputs are registered. din_ready is combinational from state and en.
- States:
  - IDLE: din_ready=en. On an edge with en && din_valid, latch din. sout<=din[DW-1], sof<=1, sout_valid<=1, rem<=din[DW-1] mod DIV, go to SHIFT with bit index DW-2.
  - SHIFT: each enabled edge launches the next lower bit b. rem<=(2*rem+b) mod DIV, computed as 2*rem+b minus DIV if that sum is >=DIV (single conditional subtract, width clog2(DIV)+1). After bit 0 is launched, go to TAG.
  - TAG: on the enabled edge entering TAG, sout<=(rem==0), eof<=1. If that tag is 1, mult_cnt<=mult_cnt+1 (mod 2^CW). din_ready=en in TAG, so a word accepted there starts its frame on the next edge with sof=1 (no bubble). Without a new word, return to IDLE with sout_valid<=0.
- Latency: handshake at edge N puts the MSB on sout from N+1. A frame is DW+1 consecutive valid cycles; the tag appears at N+DW+1.
- en low:
  - din_ready=0 and no handshake occurs.
  - In SHIFT/TAG, state, shift register and remainder freeze. sout_valid, sof and eof are driven 0 for paused cycles. sout holds its last value.
  - When en rises again, the frame resumes with the next bit; no bit is lost or repeated.
- Simultaneous rst and handshake: rst wins and the word is dropped.
- din_valid with en low is ignored; the upstream source must hold it.
- din is sampled only at the handshake edge; changes mid-frame have no effect.

Decomposition:
- Package mult5_pkg:
  - state enum (IDLE, SHIFT, TAG)
  - default constants DW=6, DIV=5, CW=8
  - function rem_step(rem, bit, DIV) returning the next remainder
- One natural sub-module: mod_rem_fsm. It holds the remainder register, with clear, step and bit inputs and an is_zero output. The transmitter instantiates it. A future serial receiver reuses it.

Test Plan:
- Reset then din=45 (101101b) with en=1 → sout bits 1,0,1,1,0,1 then tag 1. sof on bit 1, eof on the tag; mult_cnt=1.
- din=63 → bits 1,1,1,1,1,1, tag 0 (63 mod 5=3); mult_cnt unchanged. din=0 → six 0s, tag 1.
- Back-to-back din=5 then din=7, din_valid held → 14 consecutive valid cycles. Frame 2 sof directly after frame 1 eof; tags 1,0.
- din=50, en dropped for 3 cycles after the 3rd bit → sout_valid=0 for 3 cycles. The remaining bits 0,1,0 follow, then tag 1; total valid cycles = 7.
- rst pulsed during the 4th bit of din=25 → next cycle sout_valid=0, mult_cnt=0, din_ready=1. A following din=10 frame is correct with tag 1.
- Sweep din=0..63 with en=1, then 0..63 with en=0 → exactly 13 tags=1 in the first sweep (0,5,…,60), mult_cnt=13. No frames and no counter change in the second sweep.
